// File: rtl/tspp_prefetch_pkg.sv
// Shared types for the prefetching fetch stage: FIFO entry layout and fetch FSM states.
package tspp_prefetch_pkg;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } fetch_entry_t;

   typedef enum logic {
      FETCH   = 1'b0,
      DISCARD = 1'b1
   } fetch_state_t;

   localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;

endpackage

// File: rtl/tspp_prefetch_fifo.sv
// Power-of-two FIFO with registered storage; flush dominates push/pop in the same cycle.
module tspp_prefetch_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic [31:0]
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  T                           push_data_i,
   output T                           head_o,
   output logic                       valid_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   T               mem_q [DEPTH];
   logic [PW-1:0]  wr_q, rd_q;
   logic [CW-1:0]  cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_q] <= push_data_i;
            wr_q        <= wr_q + PW'(1);
         end
         if (pop_i) rd_q <= rd_q + PW'(1);
         cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
      end
   end

   assign head_o  = mem_q[rd_q];
   assign valid_o = (cnt_q != '0);
   assign count_o = cnt_q;

endmodule

// File: rtl/tspp_prefetch_fetch_stage.sv
// Fetch stage: issues sequential word reads ahead of demand into a prefetch FIFO;
// redirects flush the FIFO and any in-flight read is completed and thrown away.
module tspp_prefetch_fetch_stage
   import tspp_prefetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h8000_0000,
   parameter int          DEPTH     = 4,
   parameter bit          BYTE_SWAP = 1'b0
) (
   input  logic                       CLK,
   input  logic                       nRST,
   input  logic                       redirect_i,
   input  logic [31:0]                redirect_pc_i,
   input  logic                       out_ready_i,
   output logic                       out_valid_o,
   output logic [31:0]                out_instr_o,
   output logic [31:0]                out_pc_o,
   output logic [31:0]                out_pc4_o,
   output logic [31:0]                bus_addr_o,
   output logic                       bus_ren_o,
   output logic                       bus_wen_o,
   output logic [3:0]                 bus_byte_en_o,
   input  logic                       bus_busy_i,
   input  logic [31:0]                bus_rdata_i,
   output logic                       mal_insn_o,
   output logic [31:0]                badaddr_o,
   output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);
   localparam int            CW      = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   fetch_state_t  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   addr_q;
   logic          pend_q, run_q;
   logic          mal, done, push, pop;
   logic [31:0]   rdata_sw;
   logic [CW-1:0] count;
   fetch_entry_t  push_data, head;

   generate
      if (BYTE_SWAP) begin : g_swap
         assign rdata_sw = {bus_rdata_i[7:0], bus_rdata_i[15:8],
                            bus_rdata_i[23:16], bus_rdata_i[31:24]};
      end else begin : g_noswap
         assign rdata_sw = bus_rdata_i;
      end
   endgenerate

   assign mal = |(fetch_pc_q & WORD_ALIGN_MASK);

   // An accepted-but-busy read keeps ren and its address until it completes,
   // regardless of state, redirects or FIFO space.
   assign bus_ren_o     = pend_q | (run_q && state_q == FETCH && !mal && count < DEPTH_C);
   assign bus_addr_o    = pend_q ? addr_q : fetch_pc_q;
   assign bus_wen_o     = 1'b0;
   assign bus_byte_en_o = 4'b1111;
   assign done          = bus_ren_o & ~bus_busy_i;

   assign mal_insn_o  = mal;
   assign badaddr_o   = mal ? fetch_pc_q : 32'h0;
   assign occupancy_o = count;

   assign push_data = '{instr: rdata_sw, pc: fetch_pc_q, pc4: fetch_pc_q + 32'd4};
   assign pop       = out_valid_o & out_ready_i & ~redirect_i;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      push       = 1'b0;
      case (state_q)
         FETCH: begin
            if (done && !redirect_i) begin
               push       = 1'b1;
               fetch_pc_d = fetch_pc_q + 32'd4;
            end
         end
         DISCARD: if (done) state_d = FETCH;
         default: state_d = FETCH;
      endcase
      if (redirect_i) begin
         fetch_pc_d = redirect_pc_i;
         state_d    = (bus_ren_o && bus_busy_i) ? DISCARD : FETCH;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= FETCH;
         fetch_pc_q <= RESET_PC;
         addr_q     <= 32'h0;
         pend_q     <= 1'b0;
         run_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= bus_addr_o;
         pend_q     <= bus_ren_o & bus_busy_i;
         run_q      <= 1'b1;
      end
   end

   tspp_prefetch_fifo #(
      .DEPTH (DEPTH),
      .T     (fetch_entry_t)
   ) u_fifo (
      .clk_i       (CLK),
      .rst_ni      (nRST),
      .push_i      (push),
      .pop_i       (pop),
      .flush_i     (redirect_i),
      .push_data_i (push_data),
      .head_o      (head),
      .valid_o     (out_valid_o),
      .count_o     (count)
   );

   assign out_instr_o = head.instr;
   assign out_pc_o    = head.pc;
   assign out_pc4_o   = head.pc4;

endmodule

// File: tb/tb_tspp_prefetch_fetch_stage.sv
// Directed bench: expected {pc,instr} entries queued by the stimulus, checked as execute pops them.
module tb_tspp_prefetch_fetch_stage;
   logic        CLK, nRST;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        out_ready_i;
   logic        out_valid_o;
   logic [31:0] out_instr_o, out_pc_o, out_pc4_o;
   logic [31:0] bus_addr_o;
   logic        bus_ren_o, bus_wen_o;
   logic [3:0]  bus_byte_en_o;
   logic        bus_busy_i;
   logic [31:0] bus_rdata_i;
   logic        mal_insn_o;
   logic [31:0] badaddr_o;
   logic [2:0]  occupancy_o;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   rd_cnt = 0;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return (a == 32'h0000_0300) ? 32'h1300_0000 : (a ^ 32'h1357_9BDF);
   endfunction

   function automatic logic [31:0] bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   assign bus_rdata_i = bus_busy_i ? 32'hDEAD_BEEF : data_of(bus_addr_o);

   tspp_prefetch_fetch_stage #(
      .RESET_PC  (32'h8000_0000),
      .DEPTH     (4),
      .BYTE_SWAP (1'b1)
   ) dut (
      .CLK           (CLK),
      .nRST          (nRST),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .out_ready_i   (out_ready_i),
      .out_valid_o   (out_valid_o),
      .out_instr_o   (out_instr_o),
      .out_pc_o      (out_pc_o),
      .out_pc4_o     (out_pc4_o),
      .bus_addr_o    (bus_addr_o),
      .bus_ren_o     (bus_ren_o),
      .bus_wen_o     (bus_wen_o),
      .bus_byte_en_o (bus_byte_en_o),
      .bus_busy_i    (bus_busy_i),
      .bus_rdata_i   (bus_rdata_i),
      .mal_insn_o    (mal_insn_o),
      .badaddr_o     (badaddr_o),
      .occupancy_o   (occupancy_o)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic mid();
      @(negedge CLK);
   endtask

   task automatic push_exp(input logic [31:0] pc);
      exp_t e;
      e.pc    = pc;
      e.instr = bswap(data_of(pc));
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input string tag, input int max);
      for (int i = 0; i < max && exp_q.size() != 0; i++) cyc();
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      cyc();
      redirect_i    = 1'b1;
      redirect_pc_i = pc;
      exp_q.delete();
      mid();
      cyc();
      redirect_i = 1'b0;
   endtask

   // Execute-side scoreboard: each real pop must match the oldest queued expectation.
   always @(negedge CLK) begin
      if (nRST && out_valid_o && out_ready_i && !redirect_i && exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("out_pc", out_pc_o, e.pc);
         chk("out_instr", out_instr_o, e.instr);
         chk("out_pc4", out_pc4_o, e.pc + 32'd4);
      end
   end

   always @(negedge CLK) if (nRST && bus_ren_o && !bus_busy_i) rd_cnt++;

   initial begin
      exp_t e;
      nRST = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
      out_ready_i = 1'b1; bus_busy_i = 1'b0;
      push_exp(32'h8000_0000); push_exp(32'h8000_0004); push_exp(32'h8000_0008);
      mid(); mid();
      chk("rst_valid", 32'(out_valid_o), 32'd0);
      chk("rst_ren", 32'(bus_ren_o), 32'd0);
      chk("rst_occ", 32'(occupancy_o), 32'd0);
      chk("rst_mal", 32'(mal_insn_o), 32'd0);
      chk("rst_badaddr", badaddr_o, 32'h0);
      chk("rst_instr", out_instr_o, 32'h0);
      chk("rst_pc", out_pc_o, 32'h0);
      chk("rst_pc4", out_pc4_o, 32'h0);
      chk("wen_tie", 32'(bus_wen_o), 32'd0);
      chk("byte_en_tie", 32'(bus_byte_en_o), 32'hF);

      // Reset release: ren one edge later, first valid two edges later.
      cyc(); nRST = 1'b1;
      mid(); chk("rel_ren0", 32'(bus_ren_o), 32'd0);
      cyc(); mid();
      chk("rel_ren1", 32'(bus_ren_o), 32'd1);
      chk("rel_addr1", bus_addr_o, 32'h8000_0000);
      chk("rel_valid1", 32'(out_valid_o), 32'd0);
      cyc(); mid();
      chk("rel_valid2", 32'(out_valid_o), 32'd1);
      wait_drain("drain_reset", 20);

      // Fill with execute stalled: exactly DEPTH reads, then one more per pop.
      cyc(); out_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h1000; exp_q.delete();
      mid();
      cyc(); redirect_i = 1'b0; rd_cnt = 0;
      mid();
      chk("fill_addr0", bus_addr_o, 32'h1000);
      chk("fill_occ0", 32'(occupancy_o), 32'd0);
      repeat (8) cyc();
      mid();
      chk("fill_reads", 32'(rd_cnt), 32'd4);
      chk("fill_ren", 32'(bus_ren_o), 32'd0);
      chk("fill_occ", 32'(occupancy_o), 32'd4);
      chk("fill_head", out_pc_o, 32'h1000);
      cyc(); push_exp(32'h1000); out_ready_i = 1'b1;
      mid();
      cyc(); out_ready_i = 1'b0;
      mid();
      chk("pop_occ", 32'(occupancy_o), 32'd3);
      chk("pop_ren", 32'(bus_ren_o), 32'd1);
      chk("pop_addr", bus_addr_o, 32'h1010);
      cyc(); mid();
      chk("pop_refill_occ", 32'(occupancy_o), 32'd4);
      chk("pop_refill_reads", 32'(rd_cnt), 32'd5);

      // Redirect during a busy read of 0x80000008.
      cyc(); redirect_i = 1'b1; redirect_pc_i = 32'h8000_0000; out_ready_i = 1'b1; exp_q.delete();
      mid();
      cyc(); redirect_i = 1'b0; push_exp(32'h8000_0000); push_exp(32'h8000_0004);
      mid();
      cyc(); mid();
      cyc(); bus_busy_i = 1'b1;
      mid();
      chk("busy_ren", 32'(bus_ren_o), 32'd1);
      chk("busy_addr", bus_addr_o, 32'h8000_0008);
      cyc(); redirect_i = 1'b1; redirect_pc_i = 32'h100;
      mid();
      chk("busy_redir_addr", bus_addr_o, 32'h8000_0008);
      chk("busy_pre_drain", 32'(exp_q.size()), 32'd0);
      cyc(); redirect_i = 1'b0;
      mid();
      chk("disc_ren", 32'(bus_ren_o), 32'd1);
      chk("disc_addr", bus_addr_o, 32'h8000_0008);
      chk("disc_occ", 32'(occupancy_o), 32'd0);
      cyc(); bus_busy_i = 1'b0; push_exp(32'h100); push_exp(32'h104);
      mid();
      chk("disc_done_addr", bus_addr_o, 32'h8000_0008);
      cyc(); mid();
      chk("disc_next_addr", bus_addr_o, 32'h100);
      chk("disc_next_ren", 32'(bus_ren_o), 32'd1);
      chk("disc_no_valid", 32'(out_valid_o), 32'd0);
      wait_drain("drain_discard", 20);

      // Misaligned redirect blocks fetch until an aligned redirect.
      redirect_to(32'h102);
      mid();
      chk("mal_ren", 32'(bus_ren_o), 32'd0);
      chk("mal_flag", 32'(mal_insn_o), 32'd1);
      chk("mal_badaddr", badaddr_o, 32'h102);
      repeat (3) cyc();
      mid();
      chk("mal_hold_ren", 32'(bus_ren_o), 32'd0);
      chk("mal_hold_valid", 32'(out_valid_o), 32'd0);
      redirect_to(32'h200);
      push_exp(32'h200); push_exp(32'h204);
      mid();
      chk("mal_clr", 32'(mal_insn_o), 32'd0);
      chk("mal_clr_bad", badaddr_o, 32'h0);
      chk("mal_clr_addr", bus_addr_o, 32'h200);
      wait_drain("drain_mal", 20);

      // Byte swap of bus data.
      redirect_to(32'h300);
      e.pc = 32'h300; e.instr = 32'h0000_0013; exp_q.push_back(e);
      push_exp(32'h304);
      wait_drain("drain_swap", 20);

      // 32-bit PC wrap.
      redirect_to(32'hFFFF_FFF8);
      push_exp(32'hFFFF_FFF8); push_exp(32'hFFFF_FFFC); push_exp(32'h0000_0000);
      mid(); chk("wrap_addr0", bus_addr_o, 32'hFFFF_FFF8);
      cyc(); mid(); chk("wrap_addr1", bus_addr_o, 32'hFFFF_FFFC);
      cyc(); mid(); chk("wrap_addr2", bus_addr_o, 32'h0000_0000);
      wait_drain("drain_wrap", 20);

      // Redirect with push and pop in the same cycle near full.
      cyc(); out_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h400; exp_q.delete();
      mid();
      cyc(); redirect_i = 1'b0;
      repeat (6) cyc();
      mid();
      chk("full_occ", 32'(occupancy_o), 32'd4);
      cyc(); push_exp(32'h400); out_ready_i = 1'b1;
      mid();
      cyc(); redirect_i = 1'b1; redirect_pc_i = 32'h500;
      mid();
      chk("rpp_occ", 32'(occupancy_o), 32'd3);
      chk("rpp_ren", 32'(bus_ren_o), 32'd1);
      chk("rpp_addr", bus_addr_o, 32'h410);
      cyc(); redirect_i = 1'b0; push_exp(32'h500); push_exp(32'h504);
      mid();
      chk("rpp_flush_occ", 32'(occupancy_o), 32'd0);
      chk("rpp_flush_valid", 32'(out_valid_o), 32'd0);
      chk("rpp_next_addr", bus_addr_o, 32'h500);
      wait_drain("drain_rpp", 20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
